// File: rtl/dht11_responder.sv
// dht11_responder: DHT11 sensor-side bus model; defining DHT_ERR_INJECT_EN adds corrupt_cksum to flip checksum bit 0.
module dht11_responder #(
    parameter int CLK_FREQ_HZ   = 50_000_000,
    parameter int START_MIN_US  = 18000,
    parameter int RESP_DELAY_US = 30,
    parameter int BIT0_HIGH_US  = 26,
    parameter int BIT1_HIGH_US  = 70
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dht_in,
    output logic       dht_oe,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
    output logic       busy,
    output logic       frame_done
`ifdef DHT_ERR_INJECT_EN
    ,
    input  logic       corrupt_cksum
`endif
);
    localparam int DIV = CLK_FREQ_HZ / 1_000_000;
    localparam int PW  = DIV > 1 ? $clog2(DIV) : 1;
    localparam int CW  = $clog2((START_MIN_US > 255 ? START_MIN_US : 255) + 1);
    typedef enum logic [2:0] {IDLE, MEAS_LOW, DELAY, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW} state_t;
    state_t state, state_nx;
    logic [2:0] sync;
    logic [PW-1:0] pre;
    logic [CW-1:0] cnt, dur;
    logic [39:0] shreg;
    logic [5:0] bit_cnt;
    logic [7:0] cksum, inj;
    logic fall, rise, tick, done, long_low, snap, entry;
`ifdef DHT_ERR_INJECT_EN
    assign inj = {7'd0, corrupt_cksum};
`else
    assign inj = 8'd0;
`endif
    assign cksum    = hum_int + hum_dec + temp_int + temp_dec;
    // sync[1] is the synchronised bus level, sync[2] its previous value
    assign fall     = sync[2] & ~sync[1];
    assign rise     = ~sync[2] & sync[1];
    assign tick     = pre == PW'(DIV - 1);
    assign long_low = cnt >= CW'(START_MIN_US);
    assign dur      = state == DELAY ? CW'(RESP_DELAY_US) :
                      (state == RESP_LOW || state == RESP_HIGH) ? CW'(80) :
                      state == BIT_HIGH ? (shreg[39] ? CW'(BIT1_HIGH_US) : CW'(BIT0_HIGH_US)) : CW'(50);
    assign done     = tick && cnt == dur - 1'b1;
    assign entry    = state_nx != state;
    assign dht_oe   = state inside {RESP_LOW, BIT_LOW, END_LOW};
    assign busy     = !(state inside {IDLE, MEAS_LOW});
    always_ff @(posedge clk) begin
        if (reset) begin
            sync       <= 3'b111;
            state      <= IDLE;
            pre        <= '0;
            cnt        <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            sync       <= {sync[1:0], dht_in};
            state      <= state_nx;
            pre        <= (entry || tick) ? '0 : pre + 1'b1;
            cnt        <= entry ? '0 : (tick && !(state == MEAS_LOW && long_low)) ? cnt + 1'b1 : cnt;
            frame_done <= state == END_LOW && done;
            if (snap) begin
                shreg   <= {hum_int, hum_dec, temp_int, temp_dec, cksum ^ inj};
                bit_cnt <= '0;
            end else if (state == BIT_HIGH && done) begin
                shreg   <= {shreg[38:0], 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end
    always_comb begin
        state_nx = state;
        snap     = 1'b0;
        case (state)
            IDLE:      state_nx = fall ? MEAS_LOW : IDLE;
            MEAS_LOW: begin
                snap     = rise && long_low;
                state_nx = rise ? (long_low ? DELAY : IDLE) : MEAS_LOW;
            end
            DELAY:     state_nx = done ? RESP_LOW : DELAY;
            RESP_LOW:  state_nx = done ? RESP_HIGH : RESP_LOW;
            RESP_HIGH: state_nx = done ? BIT_LOW : RESP_HIGH;
            BIT_LOW:   state_nx = done ? BIT_HIGH : BIT_LOW;
            BIT_HIGH:  state_nx = done ? (bit_cnt == 6'd39 ? END_LOW : BIT_LOW) : BIT_HIGH;
            END_LOW:   state_nx = done ? IDLE : END_LOW;
            default:   state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dht11_responder.sv
// tb_dht11_responder: table-driven and randomized frame checks against a waveform model of the DHT11 response.
module tb_dht11_responder;
    localparam int DIV   = 2;
    localparam int START = 100;
    localparam int RDLY  = 30;
    localparam int B0    = 26;
    localparam int B1    = 70;
    logic clk = 1'b0, reset = 1'b1, host_low = 1'b0;
    logic [7:0] hum_int = 8'h00, hum_dec = 8'h00, temp_int = 8'h00, temp_dec = 8'h00;
    logic dht_in, dht_oe, busy, frame_done;
`ifdef DHT_ERR_INJECT_EN
    logic corrupt_cksum = 1'b0;
`endif
    assign dht_in = ~dht_oe & ~host_low;
    dht11_responder #(
        .CLK_FREQ_HZ(DIV * 1_000_000), .START_MIN_US(START), .RESP_DELAY_US(RDLY),
        .BIT0_HIGH_US(B0), .BIT1_HIGH_US(B1)
    ) dut (
        .clk(clk), .reset(reset), .dht_in(dht_in), .dht_oe(dht_oe),
        .hum_int(hum_int), .hum_dec(hum_dec), .temp_int(temp_int), .temp_dec(temp_dec),
        .busy(busy), .frame_done(frame_done)
`ifdef DHT_ERR_INJECT_EN
        , .corrupt_cksum(corrupt_cksum)
`endif
    );
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] hi, hd, ti, td, ck;
        int pulse_us;
        bit resp;
    } vec_t;

    int checks = 0, errors = 0;
    int seg[$];
    int fd_cnt, busy_bad, delay_cyc;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_data(logic [7:0] a, logic [7:0] b, logic [7:0] c, logic [7:0] d);
        @(posedge clk);
        #1 {hum_int, hum_dec, temp_int, temp_dec} = {a, b, c, d};
    endtask

    task automatic host_pulse(int us);
        @(posedge clk);
        #1 host_low = 1'b1;
        repeat (us * DIV) @(posedge clk);
        #1 host_low = 1'b0;
    endtask

    // Records dht_oe run lengths (cycles) from the first pull-low until frame_done.
    task automatic capture();
        int level, run;
        bit seen;
        seg.delete();
        fd_cnt = 0;
        busy_bad = 0;
        delay_cyc = -1;
        for (int c = 1; c <= 1000; c++) begin
            @(negedge clk);
            if (c > 4 && !busy) busy_bad++;
            if (dht_oe) begin
                delay_cyc = c;
                break;
            end
        end
        if (delay_cyc < 0) return;
        level = 1;
        run = 1;
        seen = 1'b0;
        for (int i = 0; i < 20000 && !seen; i++) begin
            @(negedge clk);
            if (frame_done) begin
                fd_cnt++;
                seen = 1'b1;
            end else if (!busy) busy_bad++;
            if (int'(dht_oe) == level) run++;
            else begin
                seg.push_back(run);
                level = int'(dht_oe);
                run = 1;
            end
        end
        repeat (20) begin
            @(negedge clk);
            if (frame_done) fd_cnt++;
            if (busy) busy_bad++;
        end
    endtask

    task automatic check_frame(string tag, logic [39:0] exp);
        logic [39:0] bits = '0;
        int lo_bad = 0, hi_bad = 0;
        chk({tag, " resp_delay"}, 64'(delay_cyc >= RDLY * DIV && delay_cyc <= RDLY * DIV + 4), 64'd1);
        chk({tag, " segments"}, 64'(seg.size()), 64'd83);
        if (seg.size() == 83) begin
            chk({tag, " resp_low"}, 64'(seg[0]), 64'(80 * DIV));
            chk({tag, " resp_high"}, 64'(seg[1]), 64'(80 * DIV));
            for (int i = 0; i < 40; i++) begin
                bits = {bits[38:0], seg[3 + 2 * i] > 48 * DIV};
                if (seg[2 + 2 * i] != 50 * DIV) lo_bad++;
                if (seg[3 + 2 * i] != (exp[39 - i] ? B1 : B0) * DIV) hi_bad++;
            end
            chk({tag, " frame"}, 64'(bits), 64'(exp));
            chk({tag, " bit_low_errs"}, 64'(lo_bad), 64'd0);
            chk({tag, " bit_high_errs"}, 64'(hi_bad), 64'd0);
            chk({tag, " end_low"}, 64'(seg[82]), 64'(50 * DIV));
        end
        chk({tag, " frame_done_cnt"}, 64'(fd_cnt), 64'd1);
        chk({tag, " busy_errs"}, 64'(busy_bad), 64'd0);
    endtask

    task automatic check_silent(string tag, int cycles);
        int oe = 0, bz = 0, fd = 0;
        repeat (cycles) begin
            @(negedge clk);
            oe += int'(dht_oe);
            bz += int'(busy);
            fd += int'(frame_done);
        end
        chk({tag, " oe_cycles"}, 64'(oe), 64'd0);
        chk({tag, " busy_cycles"}, 64'(bz), 64'd0);
        chk({tag, " frame_done_cnt"}, 64'(fd), 64'd0);
    endtask

    function automatic logic [39:0] model(logic [7:0] a, logic [7:0] b, logic [7:0] c, logic [7:0] d);
        int s = int'(a) + int'(b) + int'(c) + int'(d);
        return {a, b, c, d, 8'(s % 256)};
    endfunction

    initial begin
        vec_t tbl[5];
        int rises;
        logic [7:0] r[4];
        tbl[0] = '{8'h37, 8'h00, 8'h18, 8'h00, 8'h4F, 120, 1'b1};
        tbl[1] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h14, 50, 1'b0};
        tbl[2] = '{8'h37, 8'h00, 8'h18, 8'h00, 8'h4F, 120, 1'b1};
        tbl[3] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC, 120, 1'b1};
        tbl[4] = '{8'h01, 8'h80, 8'h7F, 8'hFE, 8'hFE, 120, 1'b1};

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("reset dht_oe", 64'(dht_oe), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset frame_done", 64'(frame_done), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (10) @(posedge clk);

        for (int i = 0; i < 5; i++) begin
            set_data(tbl[i].hi, tbl[i].hd, tbl[i].ti, tbl[i].td);
            host_pulse(tbl[i].pulse_us);
            if (tbl[i].resp) begin
                capture();
                check_frame($sformatf("vec%0d", i), {tbl[i].hi, tbl[i].hd, tbl[i].ti, tbl[i].td, tbl[i].ck});
            end else check_silent($sformatf("vec%0d", i), 400);
        end

        // data change during the response-high phase must not reach the frame
        set_data(8'h37, 8'h00, 8'h18, 8'h00);
        host_pulse(120);
        fork
            capture();
            begin
                for (int i = 0; i < 2000 && seg.size() < 1; i++) @(negedge clk);
                @(posedge clk);
                #1 hum_int = 8'h50;
            end
        join
        check_frame("change", 40'h370018004F);

        // reset while bit 12 is being pulled low
        set_data(8'hA5, 8'h5A, 8'h3C, 8'hC3);
        host_pulse(120);
        rises = 0;
        for (int i = 0; i < 6000 && rises < 14; i++) begin
            logic p;
            p = dht_oe;
            @(negedge clk);
            if (dht_oe && !p) rises++;
        end
        repeat (5) @(negedge clk);
        chk("bit12 oe", 64'(dht_oe), 64'd1);
        chk("bit12 busy", 64'(busy), 64'd1);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midreset oe", 64'(dht_oe), 64'd0);
        chk("midreset busy", 64'(busy), 64'd0);
        chk("midreset frame_done", 64'(frame_done), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        check_silent("after_reset", 300);
        host_pulse(120);
        capture();
        check_frame("post_reset", model(8'hA5, 8'h5A, 8'h3C, 8'hC3));

        // host start pulse during bit 20 is ignored
        set_data(8'h41, 8'h02, 8'h19, 8'h07);
        host_pulse(120);
        fork
            capture();
            begin
                for (int i = 0; i < 8000 && seg.size() < 42; i++) @(negedge clk);
                host_pulse(120);
            end
        join
        check_frame("host_mid", 40'h4102190763);
        check_silent("host_mid_after", 200);

        // randomized frame against the arithmetic model
        for (int k = 0; k < 4; k++) r[k] = 8'($urandom);
        set_data(r[0], r[1], r[2], r[3]);
        host_pulse(120);
        capture();
        check_frame("random", model(r[0], r[1], r[2], r[3]));

`ifdef DHT_ERR_INJECT_EN
        set_data(8'h37, 8'h00, 8'h18, 8'h00);
        corrupt_cksum = 1'b1;
        host_pulse(120);
        capture();
        check_frame("corrupt", 40'h370018004E);
        corrupt_cksum = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
